// File: rtl/gpio_key_pkg.sv
// gpio_key_pkg: shared constants and counter sizing for the key debouncer
package gpio_key_pkg;
    localparam int DEFAULT_STABLE_CYCLES = 240000;
    localparam int MIN_SYNC_STAGES = 2;
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction
endpackage

// File: rtl/gpio_key_debounce_ch.sv
// gpio_key_debounce_ch: one channel -- synchroniser, stability counter, level and edge registers (edges need GPIO_KEY_DEBOUNCE_EDGE_EN)
module gpio_key_debounce_ch
    import gpio_key_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = MIN_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic n,
    output logic key_o,
    output logic press_o,
    output logic release_o
);
    localparam int SS = SYNC_STAGES < MIN_SYNC_STAGES ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    logic [SS-1:0] sync;
    logic [CW-1:0] cnt, cnt_next;
    logic s, key_next;
    assign s = sync[SS-1];
    // shift the normalised pad through the synchroniser chain
    always_ff @(posedge clock)
        if (reset) sync <= '0;
        else sync <= {sync[SS-2:0], n};
    // a differing level is accepted only after LAST+1 consecutive cycles; any agreement restarts
    always_comb begin
        key_next = (s != key_o && cnt == LAST) ? s : key_o;
        cnt_next = (s == key_o || cnt == LAST) ? '0 : cnt + CW'(1);
    end
    // level and counter state
    always_ff @(posedge clock)
        if (reset) begin
            key_o <= 1'b0;
            cnt   <= '0;
        end else begin
            key_o <= key_next;
            cnt   <= cnt_next;
        end
`ifdef GPIO_KEY_DEBOUNCE_EDGE_EN
    // strobes land in the same cycle the new level first appears on key_o
    always_ff @(posedge clock)
        if (reset) begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            press_o   <= key_next & ~key_o;
            release_o <= ~key_next & key_o;
        end
`else
    assign press_o   = 1'b0;
    assign release_o = 1'b0;
`endif
endmodule

// File: rtl/gpio_key_debounce.sv
// gpio_key_debounce: multi-channel key conditioner; press/release strobes built only with GPIO_KEY_DEBOUNCE_EDGE_EN
module gpio_key_debounce
    import gpio_key_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = MIN_SYNC_STAGES,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_i,
    output logic [WIDTH-1:0] key_o,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o
);
    logic [WIDTH-1:0] n;
    assign n = (ACTIVE_LOW != 0) ? ~key_i : key_i;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        gpio_key_debounce_ch #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .n        (n[i]),
            .key_o    (key_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i])
        );
    end
endmodule

// File: tb/tb_gpio_key_debounce.sv
// tb_gpio_key_debounce: scenario tasks with a per-cycle expectation scoreboard
module tb_gpio_key_debounce;
    typedef struct packed {
        logic       rst;
        logic [1:0] key;
        logic [1:0] k;
        logic [1:0] p;
        logic [1:0] r;
    } step_t;
`ifdef GPIO_KEY_DEBOUNCE_EDGE_EN
    localparam logic [1:0] EDGE_MASK = 2'b11;
`else
    localparam logic [1:0] EDGE_MASK = 2'b00;
`endif
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] key_i = 2'b11;
    logic [1:0] key_o, press_o, release_o;
    int         n_cmp = 0;
    int         n_bad = 0;
    step_t      q[$];

    gpio_key_debounce #(
        .WIDTH(2), .STABLE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key_i    (key_i),
        .key_o    (key_o),
        .press_o  (press_o),
        .release_o(release_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic rst, input logic [1:0] key, input logic [1:0] k,
                        input logic [1:0] p, input logic [1:0] r);
        q.push_back('{rst: rst, key: key, k: k, p: p & EDGE_MASK, r: r & EDGE_MASK});
    endtask

    task automatic idle_reset();
        reset = 1'b1;
        key_i = 2'b11;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        step_t e;
        for (int c = 1; c <= 23; c++) push(c <= 3, 2'b11, 2'b00, 2'b00, 2'b00);
        for (int c = 1; c <= 23; c++) begin
            e = q.pop_front();
            reset = e.rst;
            key_i = e.key;
            @(posedge clock);
            #1;
            n_cmp++;
            if ({key_o, press_o, release_o} !== {e.k, e.p, e.r}) begin
                n_bad++;
                $display("FAIL reset c%0d: got k=%b p=%b r=%b want k=%b p=%b r=%b",
                         c, key_o, press_o, release_o, e.k, e.p, e.r);
            end
        end
    endtask

    task automatic test_press_release();
        step_t e;
        for (int c = 1; c <= 10; c++)
            push(1'b0, 2'b10, c >= 6 ? 2'b01 : 2'b00, c == 6 ? 2'b01 : 2'b00, 2'b00);
        for (int c = 1; c <= 10; c++)
            push(1'b0, 2'b11, c >= 6 ? 2'b00 : 2'b01, 2'b00, c == 6 ? 2'b01 : 2'b00);
        for (int c = 1; c <= 20; c++) begin
            e = q.pop_front();
            reset = e.rst;
            key_i = e.key;
            @(posedge clock);
            #1;
            n_cmp++;
            if ({key_o, press_o, release_o} !== {e.k, e.p, e.r}) begin
                n_bad++;
                $display("FAIL press_release c%0d: got k=%b p=%b r=%b want k=%b p=%b r=%b",
                         c, key_o, press_o, release_o, e.k, e.p, e.r);
            end
        end
    endtask

    task automatic test_bounce();
        step_t e;
        logic  k0;
        for (int c = 1; c <= 22; c++) begin
            k0 = (c <= 12) ? logic'(((c - 1) / 2) % 2) : 1'b0;
            push(1'b0, {1'b1, k0}, c >= 18 ? 2'b01 : 2'b00, c == 18 ? 2'b01 : 2'b00, 2'b00);
        end
        for (int c = 1; c <= 22; c++) begin
            e = q.pop_front();
            reset = e.rst;
            key_i = e.key;
            @(posedge clock);
            #1;
            n_cmp++;
            if ({key_o, press_o, release_o} !== {e.k, e.p, e.r}) begin
                n_bad++;
                $display("FAIL bounce c%0d: got k=%b p=%b r=%b want k=%b p=%b r=%b",
                         c, key_o, press_o, release_o, e.k, e.p, e.r);
            end
        end
        idle_reset();
    endtask

    task automatic test_glitch();
        step_t e;
        for (int c = 1; c <= 15; c++) push(1'b0, c <= 3 ? 2'b01 : 2'b11, 2'b00, 2'b00, 2'b00);
        for (int c = 1; c <= 15; c++) begin
            e = q.pop_front();
            reset = e.rst;
            key_i = e.key;
            @(posedge clock);
            #1;
            n_cmp++;
            if ({key_o, press_o, release_o} !== {e.k, e.p, e.r}) begin
                n_bad++;
                $display("FAIL glitch c%0d: got k=%b p=%b r=%b want k=%b p=%b r=%b",
                         c, key_o, press_o, release_o, e.k, e.p, e.r);
            end
        end
    endtask

    task automatic test_simultaneous();
        step_t e;
        for (int c = 1; c <= 8; c++)
            push(1'b0, 2'b01, c >= 6 ? 2'b10 : 2'b00, c == 6 ? 2'b10 : 2'b00, 2'b00);
        for (int c = 1; c <= 8; c++)
            push(1'b0, 2'b10, c >= 6 ? 2'b01 : 2'b10, c == 6 ? 2'b01 : 2'b00, c == 6 ? 2'b10 : 2'b00);
        for (int c = 1; c <= 16; c++) begin
            e = q.pop_front();
            reset = e.rst;
            key_i = e.key;
            @(posedge clock);
            #1;
            n_cmp++;
            if ({key_o, press_o, release_o} !== {e.k, e.p, e.r}) begin
                n_bad++;
                $display("FAIL simultaneous c%0d: got k=%b p=%b r=%b want k=%b p=%b r=%b",
                         c, key_o, press_o, release_o, e.k, e.p, e.r);
            end
        end
        idle_reset();
    endtask

    task automatic test_reset_midcount();
        step_t e;
        for (int c = 1; c <= 14; c++)
            push(c == 5, 2'b10, c >= 11 ? 2'b01 : 2'b00, c == 11 ? 2'b01 : 2'b00, 2'b00);
        for (int c = 1; c <= 14; c++) begin
            e = q.pop_front();
            reset = e.rst;
            key_i = e.key;
            @(posedge clock);
            #1;
            n_cmp++;
            if ({key_o, press_o, release_o} !== {e.k, e.p, e.r}) begin
                n_bad++;
                $display("FAIL reset_midcount c%0d: got k=%b p=%b r=%b want k=%b p=%b r=%b",
                         c, key_o, press_o, release_o, e.k, e.p, e.r);
            end
        end
        idle_reset();
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
